// File: rtl/t2mi_packet_dispatcher.sv
// Purpose: routes parsed T2-MI packets to the TS or BB channel, drops or aborts bad ones, keeps saturating stats.
// Latency: every output is registered; each output strobe trails its input event by exactly 1 clk.
// Backpressure: consumer ready is sampled once at the header strobe; a not-ready channel causes a whole-packet drop.
module t2mi_packet_dispatcher #(
    parameter logic [7:0]  TS_TYPE = 8'h20,
    parameter logic [7:0]  BB_TYPE = 8'h00,
    parameter logic [15:0] MAX_LEN = 16'd4096,
    parameter int          CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             in_start,
    input  logic [7:0]       in_type,
    input  logic [15:0]      in_length,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             in_end,
    input  logic             sync_locked,
    input  logic             parser_error,
    input  logic             ts_ready,
    output logic             ts_start,
    output logic             ts_valid,
    output logic             ts_end,
    output logic             ts_abort,
    output logic [7:0]       ts_data,
    input  logic             bb_ready,
    output logic             bb_start,
    output logic             bb_valid,
    output logic             bb_end,
    output logic             bb_abort,
    output logic [7:0]       bb_data,
    output logic [7:0]       out_type,
    output logic [15:0]      out_length,
    output logic             busy,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] drop_count,
    output logic [CNT_W-1:0] abort_count,
    output logic [CNT_W-1:0] other_count
);

    typedef enum logic [1:0] {IDLE, FORWARD, DROP} state_t;

    state_t      state, state_nxt;
    logic        dest_bb, dest_bb_nxt;
    logic [15:0] len_q, len_nxt;
    logic [15:0] cnt_q, cnt_nxt;
    logic [7:0]  out_type_nxt;
    logic [15:0] out_length_nxt;
    logic        start_n, valid_n, end_n, abort_n;
    logic        inc_pkt, inc_drop, inc_abort, inc_other;
    logic        is_ts, is_bb, sel_rdy;

    assign is_ts   = (in_type == TS_TYPE);
    assign is_bb   = (in_type == BB_TYPE);
    assign sel_rdy = is_ts ? ts_ready : bb_ready;
    assign busy    = (state != IDLE);

    // Next-state, per-cycle strobe and statistics-increment decode
    always_comb begin
        state_nxt      = state;
        dest_bb_nxt    = dest_bb;
        len_nxt        = len_q;
        cnt_nxt        = cnt_q;
        out_type_nxt   = out_type;
        out_length_nxt = out_length;
        start_n        = 1'b0;
        valid_n        = 1'b0;
        end_n          = 1'b0;
        abort_n        = 1'b0;
        inc_pkt        = 1'b0;
        inc_drop       = 1'b0;
        inc_abort      = 1'b0;
        inc_other      = 1'b0;
        case (state)
            IDLE: begin
                if (in_start) begin
                    if (!enable || !sync_locked) begin
                        state_nxt = DROP;
                        inc_drop  = 1'b1;
                    end else if (!is_ts && !is_bb) begin
                        state_nxt = DROP;
                        inc_other = 1'b1;
                    end else if (in_length == 16'd0 || in_length > MAX_LEN || !sel_rdy) begin
                        state_nxt = DROP;
                        inc_drop  = 1'b1;
                    end else begin
                        state_nxt      = FORWARD;
                        dest_bb_nxt    = !is_ts;
                        len_nxt        = in_length;
                        cnt_nxt        = 16'd0;
                        start_n        = 1'b1;
                        out_type_nxt   = in_type;
                        out_length_nxt = in_length;
                    end
                end
            end
            FORWARD: begin
                if (parser_error || !sync_locked || !enable || in_start) begin
                    // Byte in flight this cycle is discarded; swallow the rest if more follow
                    abort_n   = 1'b1;
                    inc_abort = 1'b1;
                    state_nxt = (in_valid && !in_end) ? DROP : IDLE;
                end else if (in_valid && cnt_q == len_q) begin
                    // More bytes than the header announced
                    abort_n   = 1'b1;
                    inc_abort = 1'b1;
                    state_nxt = in_end ? IDLE : DROP;
                end else if (in_valid) begin
                    valid_n = 1'b1;
                    cnt_nxt = cnt_q + 16'd1;
                    if (in_end) begin
                        state_nxt = IDLE;
                        if (cnt_q + 16'd1 == len_q) begin
                            end_n   = 1'b1;
                            inc_pkt = 1'b1;
                        end else begin
                            abort_n   = 1'b1;
                            inc_abort = 1'b1;
                        end
                    end
                end
            end
            DROP: begin
                if (in_end || parser_error || !sync_locked) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, packet context and channel output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            dest_bb    <= 1'b0;
            len_q      <= 16'd0;
            cnt_q      <= 16'd0;
            out_type   <= 8'h00;
            out_length <= 16'd0;
            ts_start   <= 1'b0;
            ts_valid   <= 1'b0;
            ts_end     <= 1'b0;
            ts_abort   <= 1'b0;
            ts_data    <= 8'h00;
            bb_start   <= 1'b0;
            bb_valid   <= 1'b0;
            bb_end     <= 1'b0;
            bb_abort   <= 1'b0;
            bb_data    <= 8'h00;
        end else begin
            state      <= state_nxt;
            dest_bb    <= dest_bb_nxt;
            len_q      <= len_nxt;
            cnt_q      <= cnt_nxt;
            out_type   <= out_type_nxt;
            out_length <= out_length_nxt;
            ts_start   <= start_n & ~dest_bb_nxt;
            ts_valid   <= valid_n & ~dest_bb_nxt;
            ts_end     <= end_n   & ~dest_bb_nxt;
            ts_abort   <= abort_n & ~dest_bb_nxt;
            ts_data    <= (valid_n && !dest_bb_nxt) ? in_data : 8'h00;
            bb_start   <= start_n & dest_bb_nxt;
            bb_valid   <= valid_n & dest_bb_nxt;
            bb_end     <= end_n   & dest_bb_nxt;
            bb_abort   <= abort_n & dest_bb_nxt;
            bb_data    <= (valid_n && dest_bb_nxt) ? in_data : 8'h00;
        end
    end

    // Saturating statistics counters; they hold at all-ones instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_count   <= '0;
            drop_count  <= '0;
            abort_count <= '0;
            other_count <= '0;
        end else begin
            if (inc_pkt   && pkt_count   != '1) pkt_count   <= pkt_count   + 1'b1;
            if (inc_drop  && drop_count  != '1) drop_count  <= drop_count  + 1'b1;
            if (inc_abort && abort_count != '1) abort_count <= abort_count + 1'b1;
            if (inc_other && other_count != '1) other_count <= other_count + 1'b1;
        end
    end

endmodule
